// File: rtl/fb_write_arbiter_if.sv
// Request/grant bundle between the drawing requesters and fb_write_arbiter.
// The master side is the requester/scan side; the slave side is the arbiter.
interface fb_write_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12
);
   logic                    vblank;
   logic                    frame_start;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic                    fb_we;
   logic [ADDR_W-1:0]       fb_addr;
   logic [DATA_W-1:0]       fb_data;
   logic                    busy;
   logic                    frame_overrun;
   logic [15:0]             word_count;

   modport master (
      output vblank, frame_start, req, req_addr, req_data, req_last,
      input  gnt, ack, fb_we, fb_addr, fb_data, busy, frame_overrun, word_count
   );

   modport slave (
      input  vblank, frame_start, req, req_addr, req_data, req_last,
      output gnt, ack, fb_we, fb_addr, fb_data, busy, frame_overrun, word_count
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-based arbiter for the single frame-buffer write port;
// writes are only accepted while the scan is outside the visible window.
module fb_write_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 12,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   fb_write_arbiter_if.slave bus
);
   localparam int          IW = $clog2(N_REQ);
   localparam int          BW = $clog2(MAX_BURST + 1);
   localparam int unsigned NR = N_REQ;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]        r_state;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_gidx;
   logic [N_REQ-1:0]  r_gnt;
   logic [BW-1:0]     r_beat;
   logic              r_fb_we;
   logic [ADDR_W-1:0] r_fb_addr;
   logic [DATA_W-1:0] r_fb_data;
   logic              r_overrun;
   logic              r_vblank_d;
   logic [15:0]       r_word_count;

   logic [N_REQ-1:0]  w_ack;
   logic              w_ack_any;
   logic              w_exit;
   logic              w_found;
   logic [IW-1:0]     w_cand;
   logic [IW-1:0]     w_win;
   logic [IW-1:0]     w_ptr_next;

   always_comb begin
      w_ack = '0;
      if (r_state == ST_BURST)
         w_ack = r_gnt & bus.req & {N_REQ{bus.vblank}};
   end

   assign w_ack_any = |w_ack;

   // A burst ends on its last word, on a full burst, when the owner lets go,
   // or when the visible window starts.
   assign w_exit = (w_ack_any && (bus.req_last[r_gidx] || (r_beat == BW'(MAX_BURST - 1))))
                 || !bus.req[r_gidx] || !bus.vblank;

   always_comb begin
      w_win   = r_ptr;
      w_cand  = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NR; k++) begin
         w_cand = IW'((32'(r_ptr) + k) % NR);
         if (!w_found && bus.req[w_cand]) begin
            w_win   = w_cand;
            w_found = 1'b1;
         end
      end
   end

   assign w_ptr_next = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_gidx       <= '0;
         r_gnt        <= '0;
         r_beat       <= '0;
         r_fb_we      <= 1'b0;
         r_fb_addr    <= '0;
         r_fb_data    <= '0;
         r_overrun    <= 1'b0;
         r_vblank_d   <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_fb_we <= w_ack_any;
         if (w_ack_any) begin
            r_fb_addr <= bus.req_addr[r_gidx*ADDR_W +: ADDR_W];
            r_fb_data <= bus.req_data[r_gidx*DATA_W +: DATA_W];
         end

         r_vblank_d <= bus.vblank;
         r_overrun  <= r_vblank_d & ~bus.vblank & (|bus.req);

         // frame_start restarts the count but still counts a coincident word
         if (bus.frame_start)
            r_word_count <= {15'd0, w_ack_any};
         else if (w_ack_any && (r_word_count != 16'hFFFF))
            r_word_count <= r_word_count + 16'd1;

         case (r_state)
            ST_IDLE: begin
               if (bus.vblank && (|bus.req)) begin
                  r_gnt   <= N_REQ'(1) << w_win;
                  r_gidx  <= w_win;
                  r_beat  <= '0;
                  r_state <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (w_ack_any)
                  r_beat <= r_beat + 1'b1;
               if (w_exit) begin
                  r_gnt   <= '0;
                  r_state <= ST_GAP;
               end
            end
            ST_GAP: begin
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt           = r_gnt;
   assign bus.ack           = w_ack;
   assign bus.fb_we         = r_fb_we;
   assign bus.fb_addr       = r_fb_addr;
   assign bus.fb_data       = r_fb_data;
   assign bus.busy          = (r_state != ST_IDLE);
   assign bus.frame_overrun = r_overrun;
   assign bus.word_count    = r_word_count;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: a MAX_BURST=2 instance against a behavioural model,
// and a MAX_BURST=256 instance for directed burst, blanking and saturation cases.
module tb_fb_write_arbiter;
   localparam int N    = 4;
   localparam int AW   = 17;
   localparam int DW   = 12;
   localparam int MB_A = 2;
   localparam int MB_B = 256;

   localparam int M_RAND  = 0;
   localparam int M_ROT   = 1;
   localparam int M_NOVB  = 2;
   localparam int M_FS    = 3;
   localparam int M_ONLY3 = 4;

   logic clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;
   always #5 clk = ~clk;

   fb_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
   fb_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

   fb_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB_A)) u_dut_a (
      .clk(clk), .reset_n(rst_a_n), .bus(bus_a.slave));
   fb_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB_B)) u_dut_b (
      .clk(clk), .reset_n(rst_b_n), .bus(bus_b.slave));

   int n_checks = 0;
   int n_errors = 0;
   bit b_done   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural model of instance A: who owns the port, and cooldown after a burst
   int            m_owner;
   bit            m_gap;
   int            m_gap_from;
   int            m_beats;
   int            m_ptr;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_cnt;
   bit            m_ovr;
   bit            m_vbp;

   logic [N-1:0]  a_prev_ack;
   logic [N-1:0]  a_gnt_prev;
   bit            a_fs_done;
   bit            a_fs_now;
   bit            a_fs_check;
   logic [N-1:0]  gseq[$];

   task automatic model_reset();
      m_owner = -1; m_gap = 1'b0; m_gap_from = 0; m_beats = 0; m_ptr = 0;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0; m_ovr = 1'b0; m_vbp = 1'b0;
   endtask

   task automatic model_ack(output logic [N-1:0] ak);
      ak = '0;
      if (m_owner >= 0 && bus_a.req[m_owner] && bus_a.vblank) ak[m_owner] = 1'b1;
   endtask

   task automatic model_step(input logic [N-1:0] ak);
      bit any;
      int o;
      any = |ak;
      if (any) begin
         m_addr = bus_a.req_addr[m_owner*AW +: AW];
         m_data = bus_a.req_data[m_owner*DW +: DW];
      end
      m_we = any;
      if (bus_a.frame_start) m_cnt = any ? 1 : 0;
      else if (any && m_cnt < 65535) m_cnt++;
      m_ovr = m_vbp && !bus_a.vblank && (bus_a.req != '0);
      m_vbp = bus_a.vblank;
      if (m_gap) begin
         m_ptr = (m_gap_from + 1) % N;
         m_gap = 1'b0;
      end else if (m_owner >= 0) begin
         o = m_owner;
         if (any) m_beats++;
         if ((any && bus_a.req_last[o]) || (any && m_beats == MB_A) || !bus_a.req[o] || !bus_a.vblank) begin
            m_gap = 1'b1; m_gap_from = o; m_owner = -1;
         end
      end else if (bus_a.vblank && bus_a.req != '0) begin
         for (int k = N - 1; k >= 0; k--)
            if (bus_a.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         m_beats = 0;
      end
   endtask

   task automatic new_word(input int i, input bit last);
      bus_a.req[i] = 1'b1;
      bus_a.req_addr[i*AW +: AW] = AW'($urandom);
      bus_a.req_data[i*DW +: DW] = DW'($urandom);
      bus_a.req_last[i] = last;
   endtask

   task automatic drive_a(input int mode);
      logic [N-1:0] ak;
      bus_a.frame_start = 1'b0;
      a_fs_now = 1'b0;
      if (mode == M_NOVB) bus_a.vblank = 1'b0;
      else if (mode != M_RAND) bus_a.vblank = 1'b1;
      else begin
         if ($urandom_range(24) == 0) bus_a.vblank = ~bus_a.vblank;
         if ($urandom_range(39) == 0) bus_a.frame_start = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (mode == M_ONLY3 && i != 3) begin
            bus_a.req[i] = 1'b0;
            bus_a.req_last[i] = 1'b0;
         end else if (mode != M_RAND) begin
            if (!bus_a.req[i] || a_prev_ack[i]) new_word(i, 1'b0);
         end else if (bus_a.req[i]) begin
            if (a_prev_ack[i]) begin
               if ($urandom_range(3) != 0) new_word(i, $urandom_range(3) == 0);
               else bus_a.req[i] = 1'b0;
            end
         end else if ($urandom_range(2) == 0) new_word(i, $urandom_range(3) == 0);
      end
      if (mode == M_FS && !a_fs_done) begin
         model_ack(ak);
         if (ak != '0) begin
            bus_a.frame_start = 1'b1;
            a_fs_done = 1'b1;
            a_fs_now  = 1'b1;
         end
      end
   endtask

   task automatic compare_a();
      logic [N-1:0] ak;
      logic [N-1:0] g;
      model_ack(ak);
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      check("a.gnt", bus_a.gnt, g);
      check("a.ack", bus_a.ack, ak);
      check("a.fb_we", bus_a.fb_we, m_we);
      check("a.fb_addr", bus_a.fb_addr, m_addr);
      check("a.fb_data", bus_a.fb_data, m_data);
      check("a.busy", bus_a.busy, (m_owner >= 0) || m_gap);
      check("a.overrun", bus_a.frame_overrun, m_ovr);
      check("a.word_count", bus_a.word_count, m_cnt);
   endtask

   task automatic run_a(input int ncyc, input int mode);
      logic [N-1:0] ak;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         drive_a(mode);
         #1;
         compare_a();
         if (a_fs_check) check("a.fs_with_ack", bus_a.word_count, 16'd1);
         a_fs_check = a_fs_now;
         if (bus_a.gnt != '0 && a_gnt_prev == '0) gseq.push_back(bus_a.gnt);
         a_gnt_prev = bus_a.gnt;
         model_ack(ak);
         a_prev_ack = ak;
         model_step(ak);
      end
   endtask

   task automatic release_a();
      logic [N-1:0] ak;
      @(negedge clk);
      rst_a_n = 1'b1;
      model_ack(ak);
      a_prev_ack = ak;
      model_step(ak);
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, ".gnt"}, bus_a.gnt, 0);
      check({tag, ".ack"}, bus_a.ack, 0);
      check({tag, ".fb_we"}, bus_a.fb_we, 0);
      check({tag, ".fb_addr"}, bus_a.fb_addr, 0);
      check({tag, ".fb_data"}, bus_a.fb_data, 0);
      check({tag, ".busy"}, bus_a.busy, 0);
      check({tag, ".overrun"}, bus_a.frame_overrun, 0);
      check({tag, ".word_count"}, bus_a.word_count, 0);
   endtask

   initial begin : main_proc
      int snap;
      rst_a_n = 1'b0;
      bus_a.vblank = 1'b0; bus_a.frame_start = 1'b0; bus_a.req = '0;
      bus_a.req_last = '0; bus_a.req_addr = '0; bus_a.req_data = '0;
      a_prev_ack = '0; a_gnt_prev = '0; a_fs_done = 1'b0; a_fs_now = 1'b0; a_fs_check = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1 check_zero_a("reset");

      bus_a.vblank = 1'b1;
      release_a();
      run_a(40, M_ROT);
      check("rot.n_grants", gseq.size() >= 5, 1);
      if (gseq.size() >= 5) begin
         check("rot.g0", gseq[0], 4'b0001);
         check("rot.g1", gseq[1], 4'b0010);
         check("rot.g2", gseq[2], 4'b0100);
         check("rot.g3", gseq[3], 4'b1000);
         check("rot.g4", gseq[4], 4'b0001);
      end

      run_a(3, M_NOVB);
      snap = m_cnt;
      run_a(97, M_NOVB);
      check("novb.gnt", bus_a.gnt, 0);
      check("novb.fb_we", bus_a.fb_we, 0);
      check("novb.busy", bus_a.busy, 0);
      check("novb.word_count", bus_a.word_count, snap);

      run_a(120, M_ROT);
      run_a(8, M_FS);

      for (int k = 0; k < 10 && m_owner < 0; k++) run_a(1, M_ROT);
      @(posedge clk);
      #2 rst_a_n = 1'b0;
      #1 check_zero_a("async_rst");
      model_reset();
      bus_a.req = 4'b1000;
      bus_a.req_last = '0;
      bus_a.vblank = 1'b1;
      bus_a.frame_start = 1'b0;
      a_prev_ack = '0;
      @(posedge clk);
      release_a();
      run_a(1, M_ONLY3);
      check("rst.regrant3", bus_a.gnt, 4'b1000);
      run_a(10, M_ONLY3);

      run_a(3000, M_RAND);

      fork
         wait (b_done);
         repeat (80000) @(posedge clk);
      join_any
      disable fork;
      check("b.completed", b_done, 1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : b_proc
      int            w;
      int            exp_cnt;
      int            we_cnt;
      int            ovr_cnt;
      logic [AW-1:0] wa [4];
      logic [DW-1:0] wd [4];
      rst_b_n = 1'b0;
      bus_b.vblank = 1'b1; bus_b.frame_start = 1'b0; bus_b.req = '0;
      bus_b.req_last = '0; bus_b.req_addr = '0; bus_b.req_data = '0;
      for (int i = 0; i < 4; i++) begin
         wa[i] = AW'($urandom);
         wd[i] = DW'($urandom);
      end
      repeat (3) @(negedge clk);
      rst_b_n = 1'b1;
      @(negedge clk);

      // requester 1, four words, last on the fourth
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         w = (k == 0) ? 0 : k - 1;
         if (k <= 4) begin
            bus_b.req[1] = 1'b1;
            bus_b.req_addr[1*AW +: AW] = wa[w];
            bus_b.req_data[1*DW +: DW] = wd[w];
            bus_b.req_last[1] = (w == 3);
         end else begin
            bus_b.req = '0;
            bus_b.req_last = '0;
         end
         #1;
         check("b1.gnt", bus_b.gnt, (k >= 1 && k <= 4) ? 4'b0010 : 4'b0000);
         check("b1.ack", bus_b.ack, (k >= 1 && k <= 4) ? 4'b0010 : 4'b0000);
         check("b1.fb_we", bus_b.fb_we, k >= 2 && k <= 5);
         if (k >= 2 && k <= 5) begin
            check("b1.fb_addr", bus_b.fb_addr, wa[k-2]);
            check("b1.fb_data", bus_b.fb_data, wd[k-2]);
         end
         check("b1.busy", bus_b.busy, k >= 1 && k <= 5);
      end

      // requester 2 loses blanking after three words
      repeat (2) @(negedge clk);
      we_cnt = 0;
      ovr_cnt = 0;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         w = (k == 0) ? 0 : ((k <= 4) ? k - 1 : 3);
         bus_b.req[2] = 1'b1;
         bus_b.req_addr[2*AW +: AW] = wa[w];
         bus_b.req_data[2*DW +: DW] = wd[w];
         bus_b.req_last[2] = 1'b0;
         bus_b.vblank = (k < 4);
         #1;
         if (k >= 1 && k <= 4) check("b3.ack", bus_b.ack[2], k <= 3);
         if (k == 5) begin
            check("b3.gnt_after_fall", bus_b.gnt, 0);
            check("b3.fb_we_after_fall", bus_b.fb_we, 0);
            check("b3.overrun_pulse", bus_b.frame_overrun, 1);
         end
         we_cnt += int'(bus_b.fb_we);
         ovr_cnt += int'(bus_b.frame_overrun);
      end
      check("b3.fb_we_count", we_cnt, 3);
      check("b3.overrun_count", ovr_cnt, 1);
      bus_b.req = '0;
      bus_b.vblank = 1'b1;

      // saturation: requester 0 streams for long enough to exceed 16 bits
      @(negedge clk);
      rst_b_n = 1'b0;
      @(negedge clk);
      check("b.rst_word_count", bus_b.word_count, 0);
      bus_b.req = 4'b0001;
      bus_b.req_addr[0 +: AW] = wa[0];
      bus_b.req_data[0 +: DW] = wd[0];
      bus_b.req_last = '0;
      @(negedge clk);
      rst_b_n = 1'b1;
      exp_cnt = 0;
      for (int k = 1; k <= 70600; k++) begin
         @(negedge clk);
         if (k >= 2 && ((k - 2) % (MB_B + 2)) < MB_B && exp_cnt < 65535) exp_cnt++;
         if (k % 5000 == 0 || k == 70600) check("b.sat_word_count", bus_b.word_count, exp_cnt);
      end
      check("b.sat_ffff", bus_b.word_count, 16'hFFFF);
      b_done = 1'b1;
   end
endmodule
